// File: rtl/pq_mem_pkg.sv
// Shared encodings for the main-memory port arbiter: FSM states and
// transaction owner identifiers.
package pq_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_LD : OWN_CPU;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: a lone requester wins; on a tie either the
// loader wins (fixed priority) or the side that did not go last wins.
module rr_pick2
  import pq_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       fixed_pri,
  output owner_e     grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = OWN_CPU;
    case (req)
      2'b01:   grant = OWN_CPU;
      2'b10:   grant = OWN_LD;
      2'b11:   grant = fixed_pri ? OWN_LD : other_owner(last);
      default: grant = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the CPU datapath and the loader
// port; one access at a time, three cycles each, CPU stalled while pending.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate and latch the winner's request
// ISSUE | mem_en/mem_we driven from the latched request; write commits here
// RESP  | owner ack pulses; read data returned from memory
module mem_port_arbiter
  import pq_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = MEM_ADDR_W,
  parameter int unsigned DATA_W          = MEM_DATA_W,
  parameter int unsigned LOADER_PRIORITY = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            pick_grant;
  logic              pick_valid;
  logic              txn_we_q, txn_we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  rr_pick2 u_pick (
    .req       ({ld_req, cpu_req}),
    .last      (last_owner_q),
    .fixed_pri (LOADER_PRIORITY != 0),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    txn_we_d     = txn_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    ld_ack_d     = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_grant;
          if (pick_grant == OWN_LD) begin
            txn_we_d    = ld_we;
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
          end else begin
            txn_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
          // mem_addr/mem_wdata double as the request latch
          mem_en_d = 1'b1;
          mem_we_d = txn_we_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cpu_ack_d = (owner_q == OWN_CPU);
        ld_ack_d  = (owner_q == OWN_LD);
        state_d   = RESP;
      end
      RESP: begin
        if (!txn_we_q) begin
          if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
          else                    ld_rdata_d  = mem_rdata;
        end
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_LD;
      txn_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      ld_ack_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      txn_we_q     <= txn_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      ld_ack_q     <= ld_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ld_ack    = ld_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

  // Memory data only exists during RESP, so it is forwarded alongside the ack
  // and the register holds it afterwards.
  assign cpu_rdata = (cpu_ack_q && !txn_we_q) ? mem_rdata : cpu_rdata_q;
  assign ld_rdata  = (ld_ack_q  && !txn_we_q) ? mem_rdata : ld_rdata_q;

endmodule
